// File: rtl/key_event_sequencer.sv
// PS/2 scan-byte parser: turns make codes of mapped keys into 5-bit letter
// events, suppresses typematic repeats and extended keys, and queues letters in a small FIFO.
//
// state | meaning
// IDLE  | waiting for a make code, F0 (break prefix) or E0 (extended prefix)
// BRK   | F0 seen; the next byte is the released key
// EXT   | E0 seen; the extended key is ignored, F0 may follow
module key_event_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_stb,
    output logic [4:0] out_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       held
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BRK  = 2'd1,
        EXT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  held_code;
    logic        mapped;
    logic [4:0]  letter;
    logic        make_push;
    logic        held_clr;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    always_comb begin
        mapped = 1'b1;
        letter = 5'd0;
        case (scan_code)
            8'h1C:   letter = 5'd0;
            8'h32:   letter = 5'd1;
            8'h21:   letter = 5'd2;
            8'h23:   letter = 5'd3;
            8'h24:   letter = 5'd4;
            8'h2B:   letter = 5'd5;
            8'h33:   letter = 5'd6;
            8'h4B:   letter = 5'd7;
            8'h31:   letter = 5'd8;
            8'h44:   letter = 5'd9;
            8'h4D:   letter = 5'd10;
            8'h2D:   letter = 5'd11;
            8'h1B:   letter = 5'd12;
            8'h3C:   letter = 5'd13;
            8'h35:   letter = 5'd14;
            8'h29:   letter = 5'd20;
            default: mapped = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (scan_stb) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_nxt = BRK;
                    end else if (scan_code == 8'hE0) begin
                        state_nxt = EXT;
                    end
                end
                BRK:     state_nxt = IDLE;
                EXT:     state_nxt = (scan_code == 8'hF0) ? BRK : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A repeated make of the key already held is typematic and produces nothing.
    always_comb begin
        make_push = 1'b0;
        held_clr  = 1'b0;
        if (scan_stb) begin
            case (state)
                IDLE:    make_push = mapped && !(held && (scan_code == held_code));
                BRK:     held_clr  = (scan_code == held_code);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_code <= 8'h00;
            held      <= 1'b0;
        end else if (make_push) begin
            held_code <= scan_code;
            held      <= 1'b1;
        end else if (held_clr) begin
            held      <= 1'b0;
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full queue with a pop is kept.
    assign full    = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign do_pop  = out_valid && out_ready;
    assign do_push = make_push && (!full || do_pop);
    assign drop    = make_push && full && !do_pop;
    assign out_letter = out_valid ? mem[rd_ptr] : 5'd0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= letter;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_sequencer.sv
// Bench for key_event_sequencer: table of scan strobes with expected held state,
// a letter scoreboard checked on every pop, and hand sequences for queue/reset corners.
module tb_key_event_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] scan_code;
    logic       scan_stb;
    logic [4:0] out_letter;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       ovf_clr;
    logic       held;

    int checks   = 0;
    int failures = 0;
    logic [4:0] sb [$];

    typedef struct {
        logic [7:0] code;
        logic       push;
        logic [4:0] letter;
        logic       held;
    } vec_t;
    vec_t tbl [$];

    key_event_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_code (scan_code),
        .scan_stb  (scan_stb),
        .out_letter(out_letter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .held      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every pop the DUT performs is compared against the oldest expected letter.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pop actual=%0d required=none", out_letter);
            end else begin
                logic [4:0] exp;
                exp = sb.pop_front();
                if (out_letter !== exp) begin
                    failures++;
                    $display("FAIL pop_letter actual=%0d required=%0d", out_letter, exp);
                end
            end
        end
    end

    task automatic strobe(input logic [7:0] b);
        @(posedge clk); #1;
        scan_code = b;
        scan_stb  = 1'b1;
        @(posedge clk); #1;
        scan_stb  = 1'b0;
        scan_code = 8'hF0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        scan_code = 8'h00;
        scan_stb = 1'b0;
        out_ready = 1'b1;
        ovf_clr = 1'b0;

        tbl.push_back('{8'h1C, 1'b1, 5'd0,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h1C, 1'b1, 5'd0,  1'b1});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h1C, 1'b1, 5'd0,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'hE0, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h32, 1'b1, 5'd1,  1'b1});
        tbl.push_back('{8'hE0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h1C, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h32, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h5A, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h29, 1'b1, 5'd20, 1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h29, 1'b0, 5'd0,  1'b0});
        tbl.push_back('{8'h21, 1'b1, 5'd2,  1'b1});
        tbl.push_back('{8'h4D, 1'b1, 5'd10, 1'b1});
        tbl.push_back('{8'h35, 1'b1, 5'd14, 1'b1});
        tbl.push_back('{8'h24, 1'b1, 5'd4,  1'b1});
        tbl.push_back('{8'h2B, 1'b1, 5'd5,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h24, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'hF0, 1'b0, 5'd0,  1'b1});
        tbl.push_back('{8'h2B, 1'b0, 5'd0,  1'b0});

        #2;
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_out_letter", {27'd0, out_letter}, 32'd0);
        chk("rst_overflow",   {31'd0, overflow}, 32'd0);
        chk("rst_held",       {31'd0, held}, 32'd0);
        #21;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].push) sb.push_back(tbl[i].letter);
            strobe(tbl[i].code);
            chk($sformatf("held_vec%0d", i), {31'd0, held}, {31'd0, tbl[i].held});
        end
        wait_drain("table");

        // Fill with out_ready low: fifth make is dropped.
        out_ready = 1'b0;
        sb.push_back(5'd0); strobe(8'h1C);
        sb.push_back(5'd1); strobe(8'h32);
        sb.push_back(5'd2); strobe(8'h21);
        sb.push_back(5'd3); strobe(8'h23);
        strobe(8'h24);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stable_letter%0d", i), {27'd0, out_letter}, 32'd0);
            chk($sformatf("stable_valid%0d", i), {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("fill");
        pulse_clr();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Drop on the same cycle as ovf_clr keeps overflow set.
        out_ready = 1'b0;
        sb.push_back(5'd0); strobe(8'h1C);
        sb.push_back(5'd1); strobe(8'h32);
        sb.push_back(5'd2); strobe(8'h21);
        sb.push_back(5'd3); strobe(8'h23);
        @(posedge clk); #1;
        scan_code = 8'h24; scan_stb = 1'b1; ovf_clr = 1'b1;
        @(posedge clk); #1;
        scan_stb = 1'b0; ovf_clr = 1'b0;
        chk("drop_beats_clr", {31'd0, overflow}, 32'd1);
        pulse_clr();
        chk("ovf_cleared2", {31'd0, overflow}, 32'd0);

        // Push and pop together while full is accepted.
        sb.push_back(5'd7);
        @(posedge clk); #1;
        scan_code = 8'h4B; scan_stb = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        scan_stb = 1'b0;
        chk("full_push_pop_ovf", {31'd0, overflow}, 32'd0);
        wait_drain("full_push_pop");

        // Push into an empty queue with out_ready high: not visible that cycle.
        sb.push_back(5'd9);
        @(posedge clk); #1;
        scan_code = 8'h44; scan_stb = 1'b1;
        @(negedge clk);
        chk("empty_push_valid_low", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        scan_stb = 1'b0;
        @(negedge clk);
        chk("push_latency_valid", {31'd0, out_valid}, 32'd1);
        wait_drain("empty_push");

        // Bytes without a strobe change nothing.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            case (i % 3)
                0: scan_code = 8'hF0;
                1: scan_code = 8'hE0;
                default: scan_code = 8'h44;
            endcase
        end
        chk("nostb_held", {31'd0, held}, 32'd1);
        chk("nostb_valid", {31'd0, out_valid}, 32'd0);
        sb.push_back(5'd8);
        strobe(8'h31);
        wait_drain("after_nostb");

        // Reset mid-sequence with three queued and the parser in BRK.
        out_ready = 1'b0;
        sb.push_back(5'd0); strobe(8'h1C);
        sb.push_back(5'd1); strobe(8'h32);
        sb.push_back(5'd2); strobe(8'h21);
        strobe(8'hF0);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("mid_rst_letter", {27'd0, out_letter}, 32'd0);
        chk("mid_rst_held",   {31'd0, held}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        sb.push_back(5'd1);
        strobe(8'h32);
        chk("post_rst_held", {31'd0, held}, 32'd1);
        wait_drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_event_sequencer.md
KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the letter-event queue depth and SHALL be a power of two, 2..16.
REQ-002 Port clk, input, 1: single clock; every register SHALL be clocked on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port scan_code, input, 8: PS/2 scan byte from the HID receiver.
REQ-005 Port scan_stb, input, 1: one-cycle pulse marking scan_code as a new byte.
REQ-006 Port out_letter, output, 5: letter code at the head of the queue.
REQ-007 Port out_valid, output, 1: the queue is non-empty.
REQ-008 Port out_ready, input, 1: the consumer accepts the head entry.
REQ-009 Port overflow, output, 1: sticky flag, set when an event is dropped.
REQ-010 Port ovf_clr, input, 1: synchronous clear of overflow.
REQ-011 Port held, output, 1: a mapped key is currently held down.

Function
REQ-012 The decode map SHALL be: 1C->0, 32->1, 21->2, 23->3, 24->4, 2B->5, 33->6, 4B->7, 31->8, 44->9, 4D->10, 2D->11, 1B->12, 3C->13, 35->14, 29->20; every other byte SHALL be unmapped.
REQ-013 The parser FSM SHALL have three states: IDLE, BRK and EXT; it SHALL change state only on cycles where scan_stb=1.
REQ-014 In IDLE, byte F0 -> BRK; byte E0 -> EXT; mapped byte -> make event (REQ-017); any other byte -> stay in IDLE, no effect.
REQ-015 In BRK, any byte -> IDLE; if that byte equals the held code, held SHALL clear the next cycle; no event SHALL be queued.
REQ-016 In EXT, byte F0 -> BRK; any other byte -> IDLE; no event SHALL be queued (extended keys are ignored).
REQ-017 Make event: if held=1 and the byte equals the held code, the byte SHALL be discarded as typematic repeat; otherwise the held code SHALL be set to the byte, held=1, and the mapped letter SHALL be pushed.
REQ-018 A make of a different mapped key while one is held SHALL replace the held code and push its letter.
REQ-019 Push latency: the letter SHALL appear at out_letter with out_valid=1 on the cycle after the scan_stb cycle when the queue was empty.
REQ-020 A pop SHALL occur when out_valid & out_ready; the next entry (or out_valid=0) SHALL be visible on the following cycle.
REQ-021 out_letter SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Push when full: the letter SHALL be dropped, the queue contents SHALL be unchanged, and overflow SHALL be set to 1.
REQ-023 Push and pop on the same cycle when full SHALL be accepted with no overflow; with the queue empty, the push SHALL be queued and out_valid SHALL stay low that cycle.
REQ-024 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; a count of width log2(FIFO_DEPTH)+1 SHALL distinguish full from empty.
REQ-025 ovf_clr=1 SHALL clear overflow, except that a drop on the same cycle SHALL win and leave overflow=1.
REQ-026 scan_stb=0 cycles SHALL not alter the FSM, the held state or the queue, whatever scan_code shows.

Reset
REQ-027 While rst_n=0, asynchronously: FSM=IDLE, pointers and count=0, held code=00, held=0, out_valid=0, out_letter=0, overflow=0.
REQ-028 Reset asserted mid-sequence (e.g. in BRK with the queue partly full) SHALL discard all queued events and pending parser state.
REQ-029 The first scan_stb after rst_n rises SHALL be processed normally from IDLE.

Verification
REQ-030 Strobes 1C, F0, 1C with out_ready=1 -> exactly one letter 0; held=1 after the make and 0 after the break.
REQ-031 Strobes 1C, 1C, 1C (typematic) -> one letter 0 only; then F0, 1C, 1C -> a second letter 0.
REQ-032 out_ready=0, FIFO_DEPTH=4, makes 1C, 32, 21, 23, 24 -> queue holds 0,1,2,3 and overflow=1; raise out_ready -> 0,1,2,3 drain in order, then out_valid=0.
REQ-033 Strobes E0, 1C -> no event, FSM in IDLE; strobes E0, F0, 1C -> no event, held unchanged.
REQ-034 Unmapped 5A, then 29 -> only letter 20; ovf_clr pulsed together with a full-queue push -> overflow stays 1.
REQ-035 rst_n pulsed low with 3 entries queued and FSM in BRK -> out_valid=0 immediately; the next strobe 32 -> letter 1.
